// File: rtl/fp_sum_reduce_pkg.sv
// Shared packed-float definitions and the reducer state type.
package fp_sum_reduce_pkg;

  localparam int FP_EXP  = 8;
  localparam int FP_MANT = 7;

  function automatic int fp_width(input int exp_w, input int mant_w);
    return exp_w + mant_w + 1;
  endfunction

  localparam logic [FP_EXP+FP_MANT:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    FLUSH,
    ACCUM,
    DRAIN,
    OUTPUT
  } state_t;

endpackage

// File: rtl/fp_sum_reduce.sv
// Streaming FP vector reducer: pairs inputs, adder results and one spare
// register so a fixed-latency pipelined adder can absorb one element per cycle.
module fp_sum_reduce
  import fp_sum_reduce_pkg::*;
#(
  parameter int EXP         = FP_EXP,
  parameter int MANT        = FP_MANT,
  parameter int WIDTH       = fp_width(EXP, MANT),
  parameter int ADD_LATENCY = 3
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_dataa,
  output logic [WIDTH-1:0] add_datab,
  input  logic             add_result_valid,
  input  logic [WIDTH-1:0] add_result
);

  localparam int CNT_W = $clog2(ADD_LATENCY + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ADD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;
  logic [CNT_W-1:0]   inflight;
  logic               spare_valid;
  logic [WIDTH-1:0]   spare;

  logic pairing;
  logic res_take;
  logic in_take;

  // A result with nothing outstanding is stale or a protocol error: drop it.
  always_comb begin
    pairing  = (state == ACCUM) || (state == DRAIN);
    res_take = pairing && add_result_valid && (inflight != '0);
    in_take  = in_valid && in_ready;
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of spare_valid, inflight and add_valid.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      state       <= FLUSH;
      flush_cnt   <= '0;
      inflight    <= '0;
      spare_valid <= 1'b0;
      spare       <= WIDTH'(FP_ZERO);
      out_data    <= WIDTH'(FP_ZERO);
      add_valid   <= 1'b0;
      add_dataa   <= WIDTH'(FP_ZERO);
      add_datab   <= WIDTH'(FP_ZERO);
    end else begin
      add_valid <= 1'b0;

      case ({add_valid, res_take})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase

      if (res_take && in_take) begin
        add_valid <= 1'b1;
        add_dataa <= add_result;
        add_datab <= in_data;
      end else if (res_take && spare_valid) begin
        add_valid   <= 1'b1;
        add_dataa   <= spare;
        add_datab   <= add_result;
        spare_valid <= 1'b0;
      end else if (res_take) begin
        spare       <= add_result;
        spare_valid <= 1'b1;
      end else if (in_take && spare_valid) begin
        add_valid   <= 1'b1;
        add_dataa   <= spare;
        add_datab   <= in_data;
        spare_valid <= 1'b0;
      end else if (in_take) begin
        spare       <= in_data;
        spare_valid <= 1'b1;
      end

      case (state)
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= ACCUM;
          else flush_cnt <= flush_cnt + CNT_ONE;
        end
        ACCUM: begin
          if (in_take && in_last) state <= DRAIN;
        end
        DRAIN: begin
          // An issue still sitting in add_valid is not yet counted in inflight.
          if ((inflight == '0) && !add_valid && spare_valid) begin
            state    <= OUTPUT;
            out_data <= spare;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            spare_valid <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule
